// File: rtl/seg_pkg.sv
// Shared types and constants for the two-digit BCD seven-segment scanner.
// Segment patterns here are active-high {g,f,e,d,c,b,a}; polarity is applied at the top level.
package seg_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_ONES = 2'd1,
      ST_TENS = 2'd2
   } state_e;

   localparam logic [6:0] SEG_DIGIT_0 = 7'h3F;
   localparam logic [6:0] SEG_DIGIT_1 = 7'h06;
   localparam logic [6:0] SEG_DIGIT_2 = 7'h5B;
   localparam logic [6:0] SEG_DIGIT_3 = 7'h4F;
   localparam logic [6:0] SEG_DIGIT_4 = 7'h66;
   localparam logic [6:0] SEG_DIGIT_5 = 7'h6D;
   localparam logic [6:0] SEG_DIGIT_6 = 7'h7D;
   localparam logic [6:0] SEG_DIGIT_7 = 7'h07;
   localparam logic [6:0] SEG_DIGIT_8 = 7'h7F;
   localparam logic [6:0] SEG_DIGIT_9 = 7'h6F;
   localparam logic [6:0] SEG_DASH    = 7'h40;
   localparam logic [6:0] SEG_ALL_OFF = 7'h00;

   localparam logic [1:0] AN_NONE = 2'b11;
   localparam logic [1:0] AN_ONES = 2'b10;
   localparam logic [1:0] AN_TENS = 2'b01;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-high seven-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
   import seg_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_o = SEG_DIGIT_0;
         4'd1:    seg_o = SEG_DIGIT_1;
         4'd2:    seg_o = SEG_DIGIT_2;
         4'd3:    seg_o = SEG_DIGIT_3;
         4'd4:    seg_o = SEG_DIGIT_4;
         4'd5:    seg_o = SEG_DIGIT_5;
         4'd6:    seg_o = SEG_DIGIT_6;
         4'd7:    seg_o = SEG_DIGIT_7;
         4'd8:    seg_o = SEG_DIGIT_8;
         4'd9:    seg_o = SEG_DIGIT_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_seg_scan.sv
// Two-digit multiplexed seven-segment driver: latches a BCD pair and alternates
// the ones/tens digit every REFRESH_DIV cycles, with registered seg/an/err outputs.
module bcd_seg_scan
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV    = 50000,
   parameter bit ACTIVE_LOW_SEG = 1'b1,
   parameter bit BLANK_LZ       = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   input  logic       enable,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       err
);

   localparam int             CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);
   localparam logic [6:0]     SEG_OFF = ACTIVE_LOW_SEG ? ~SEG_ALL_OFF : SEG_ALL_OFF;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    tens_q, ones_q;
   logic [6:0]    seg_q, seg_d;
   logic [1:0]    an_q, an_d;
   logic          err_q, err_d;
   logic          tick;
   logic          blank;
   logic [3:0]    digitSel;
   logic [6:0]    patHigh;

   assign tick = (cnt_q == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
         seg_q   <= SEG_OFF;
         an_q    <= AN_NONE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         err_q   <= err_d;
         if (load) begin
            tens_q <= tens;
            ones_q <= ones;
         end
      end
   end

   // Prescaler restarts on entry from OFF so the first ONES slot is a full REFRESH_DIV long.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_OFF:  if (enable) state_d = ST_ONES;
         ST_ONES: if (enable && tick) state_d = ST_TENS;
         ST_TENS: if (enable && tick) state_d = ST_ONES;
         default: state_d = ST_OFF;
      endcase
      if (!enable) begin
         state_d = ST_OFF;
         cnt_d   = '0;
      end else if ((state_q == ST_OFF) || tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   assign digitSel = (state_q == ST_TENS) ? tens_q : ones_q;

   bcd_to_seg7 u_dec (
      .bcd_i (digitSel),
      .seg_o (patHigh)
   );

   always_comb begin
      blank = (state_q == ST_OFF) ||
              ((state_q == ST_TENS) && BLANK_LZ && (tens_q == 4'd0));
      an_d  = AN_NONE;
      case (state_q)
         ST_ONES: an_d = AN_ONES;
         ST_TENS: an_d = AN_TENS;
         default: an_d = AN_NONE;
      endcase
      if (blank) an_d = AN_NONE;
      seg_d = blank ? SEG_OFF : (ACTIVE_LOW_SEG ? ~patHigh : patHigh);
      err_d = (tens_q > 4'd9) || (ones_q > 4'd9);
   end

   assign seg = seg_q;
   assign an  = an_q;
   assign err = err_q;

endmodule

// File: doc/bcd_seg_scan.md
BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

Interface
REQ-001 The parameters SHALL be:
- REFRESH_DIV, 50000, clock cycles per digit slot; legal range >=1.
- ACTIVE_LOW_SEG, 1, 1 = segment outputs active-low (common anode); 0 = active-high.
- BLANK_LZ, 1, 1 = blank the tens digit when it is 0.
REQ-002 The ports SHALL be:
- clk  input  1  single clock; all flops rise-edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  capture strobe for tens/ones, one cycle.
- tens  input  4  BCD tens digit from the binary-to-BCD stage.
- ones  input  4  BCD ones digit from the binary-to-BCD stage.
- enable  input  1  display enable; 0 turns the display off.
- seg  output  7  segments {g,f,e,d,c,b,a}; seg[0]=a.
- an  output  2  digit enables, always active-low; an[0]=ones, an[1]=tens.
- err  output  1  high while either latched digit is >9.

Function
REQ-003 On a cycle with load=1, tens/ones SHALL be captured into tens_q/ones_q at that edge; with load=0 the latches SHALL hold.
REQ-004 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0, asserting tick in the cycle where count==REFRESH_DIV-1.
REQ-005 With REFRESH_DIV=1, tick SHALL be asserted every cycle.
REQ-006 The FSM SHALL have states OFF, ONES and TENS.
REQ-007 OFF->ONES SHALL occur at the first edge with enable=1, and the prescaler SHALL be cleared at that edge.
REQ-008 ONES->TENS and TENS->ONES SHALL occur at each edge where tick=1 and enable=1.
REQ-009 From any state, enable=0 SHALL force OFF at the next edge and clear the prescaler.
REQ-010 seg, an and err SHALL be registered, computed from state_q, tens_q and ones_q, so that a load sampled at edge k is visible on seg/err at edge k+1.
REQ-011 Digit patterns (active-high, hex) SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
REQ-012 Digit codes 10..15 SHALL display a dash (40).
REQ-013 err SHALL be 1 whenever tens_q>9 or ones_q>9, independent of FSM state.
REQ-014 In ONES, an SHALL be 2'b10 and seg SHALL show ones_q.
REQ-015 In TENS, an SHALL be 2'b01 and seg SHALL show tens_q.
REQ-016 In TENS with BLANK_LZ=1 and tens_q==0, an SHALL be 2'b11 and seg SHALL be all-off.
REQ-017 In OFF, an SHALL be 2'b11 and seg SHALL be all-off.
REQ-018 With ACTIVE_LOW_SEG=1, seg SHALL be the bitwise inverse of the active-high pattern, so all-off = 7F; with ACTIVE_LOW_SEG=0, all-off = 00.
REQ-019 When load and tick coincide, the FSM transition and the latch update SHALL both take effect at the same edge, and the new digit SHALL appear one edge later.
REQ-020 an SHALL never equal 2'b00 in any cycle.

Reset
REQ-021 When rst_n=0, the block SHALL immediately, without waiting for a clock edge, force: state=OFF, prescaler=0, tens_q=ones_q=0, an=2'b11, seg=all-off, err=0.
REQ-022 The effect of REQ-021 SHALL apply regardless of the current state, including mid-slot.
REQ-023 After rst_n deasserts, the first transition SHALL follow REQ-007.

Structure
REQ-024 A shared package seg_pkg SHALL hold the FSM state encoding, the digit pattern constants from REQ-011, the dash constant and the all-off constant.
REQ-025 The BCD-to-segment lookup SHALL be a separate combinational sub-module bcd_to_seg7 (4-bit in, 7-bit active-high out), instantiated once on the digit selected by the mux.

Verification
REQ-026 The bench SHALL run every scenario below at REFRESH_DIV=4 and SHALL check REQ-020 continuously.
- Reset: with rst_n=0 held mid-TENS -> an=11, seg=7F, err=0 before the next clk edge.
- Display 42: load tens=4, ones=2, enable=1 -> an alternates 10/01 every 4 cycles; seg=~66 on ones slot... corrected per REQ-014/015: seg=~5B=24 with an=10, seg=~66=19 with an=01.
- Leading-zero blank: load tens=0, ones=7 -> an=10 with seg=78 in the ones slot; an=11 with seg=7F in the tens slot.
- Invalid code: load tens=12, ones=3 -> err=1 one edge after load; tens slot seg=3F (dash inverted); ones slot seg=30.
- Disable and re-enable: drop enable during TENS -> OFF next edge (an=11); re-assert -> ONES with prescaler at 0, first slot exactly 4 cycles.
- Coincident events: load ones=9 on a tick edge in ONES -> TENS at that edge; the next ONES slot shows seg=10.
